sram_mem_controller: RTL and testbench

- Sits directly downstream of the MEM stage and replaces its ideal single-cycle array with an off-chip 16-bit asynchronous SRAM (256K x 16).
- Accepts the MEM stage's 32-bit word request (address, write data, wr_en/rd_en) and performs two 16-bit SRAM accesses, low half first, then high half.
- Drives ready low while busy. The hazard/freeze logic uses ready to stall every pipeline register.

---
 rtl/sram_mem_controller.sv | 118 +++++++++++
 tb/tb_sram_mem_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_controller.sv
// Bridges the MEM stage 32-bit word port to a 16-bit asynchronous SRAM.
// Each word takes two half-accesses (low half first) and stalls the pipeline via ready.
module sram_mem_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam int CW = (WAIT_CYCLES < 4) ? 2 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [16:0]     word_idx;
    logic            req;
    logic            last;
    logic            hi;

    assign word_idx  = 17'((address - 32'(BASE_ADDR)) >> 2);
    assign req       = wr_en | rd_en;
    assign last      = (cnt_q == CW'(WAIT_CYCLES));
    assign hi        = (state_q == S_HI);
    assign read_data = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        rdata_d     = rdata_q;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_ce_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_we_n   = 1'b1;
        sram_ub_n   = 1'b1;
        sram_lb_n   = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                ready = ~req;
                if (req) begin
                    wr_d    = wr_en;
                    cnt_d   = '0;
                    state_d = S_LO;
                end
            end
            S_LO, S_HI: begin
                sram_ce_n = 1'b0;
                sram_ub_n = 1'b0;
                sram_lb_n = 1'b0;
                sram_addr = {word_idx, hi};
                if (wr_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = hi ? write_data[31:16] : write_data[15:0];
                    // release we_n one cycle early so the address is stable on its rising edge
                    sram_we_n   = last;
                end else begin
                    sram_oe_n = 1'b0;
                end
                if (last) begin
                    cnt_d   = '0;
                    state_d = hi ? S_DONE : S_HI;
                    if (!wr_q) begin
                        if (hi) rdata_d[31:16] = sram_dq_in;
                        else    rdata_d[15:0]  = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                ready   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench: W=1 controller with a behavioural SRAM, plus a W=3 instance
// whose SRAM only presents valid data on the last cycle of each phase.
module tb_sram_mem_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] address = 32'd1024, write_data = 32'd0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;

    logic        wr3 = 1'b0, rd3 = 1'b0;
    logic [31:0] read_data3;
    logic        ready3;
    logic [17:0] addr3;
    logic [15:0] dq_out3, dq_in3;
    logic        dq_oe3, ce3_n, oe3_n, we3_n, ub3_n, lb3_n;
    int          c3;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    sram_mem_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data),
        .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
        .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
        .sram_ub_n(ub_n), .sram_lb_n(lb_n)
    );

    sram_mem_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr3), .rd_en(rd3),
        .address(address), .write_data(write_data),
        .read_data(read_data3), .ready(ready3),
        .sram_addr(addr3), .sram_dq_out(dq_out3),
        .sram_dq_oe(dq_oe3), .sram_dq_in(dq_in3),
        .sram_ce_n(ce3_n), .sram_oe_n(oe3_n), .sram_we_n(we3_n),
        .sram_ub_n(ub3_n), .sram_lb_n(lb3_n)
    );

    always @(posedge clk) begin
        if (!ce_n && !we_n) mem[sram_addr[7:0]] <= sram_dq_out;
    end
    assign sram_dq_in = (!ce_n && !oe_n) ? mem[sram_addr[7:0]] : 16'h0000;

    always @(posedge clk) begin
        if (ce3_n) c3 <= 0;
        else       c3 <= c3 + 1;
    end
    assign dq_in3 = (!ce3_n && !oe3_n && (c3 == 3 || c3 == 7))
                    ? (16'hA000 | addr3[15:0]) : 16'hFFFF;

    task automatic xfer(input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lows, output int wlo, output int whi,
                        output int oel, output logic [31:0] rdv,
                        output logic rdy);
        @(negedge clk);
        wr_en = w; rd_en = r; address = a; write_data = d;
        lows = 0; wlo = 0; whi = 0; oel = 0; rdv = 'x; rdy = 1'b0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (!we_n) begin
                if (sram_addr[0]) whi++;
                else              wlo++;
            end
            if (!oe_n) oel++;
            if (ready) begin
                rdy = 1'b1;
                rdv = read_data;
                break;
            end
            lows++;
            @(negedge clk);
            #1;
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
        total++; if (read_data !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", read_data); end
        total++; if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=11111", {ce_n, oe_n, we_n, ub_n, lb_n}); end
        total++; if (sram_dq_oe !== 1'b0) begin bad++; $display("FAIL reset_dq_oe got=%b exp=0", sram_dq_oe); end
        total++; if (sram_addr !== 18'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", sram_addr); end
        rst = 1'b0;
    endtask

    task automatic test_write;
        int lows, wlo, whi, oel; logic [31:0] rdv; logic rdy;
        xfer(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, lows, wlo, whi, oel, rdv, rdy);
        total++; if (lows !== 5) begin bad++; $display("FAIL wr_low_cycles got=%0d exp=5", lows); end
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL wr_done_ready got=%b exp=1", rdy); end
        total++; if (mem[2] !== 16'hBEEF) begin bad++; $display("FAIL wr_lo_word got=%h exp=beef", mem[2]); end
        total++; if (mem[3] !== 16'hDEAD) begin bad++; $display("FAIL wr_hi_word got=%h exp=dead", mem[3]); end
        total++; if (wlo !== 1) begin bad++; $display("FAIL wr_we_lo got=%0d exp=1", wlo); end
        total++; if (whi !== 1) begin bad++; $display("FAIL wr_we_hi got=%0d exp=1", whi); end
        total++; if (oel !== 0) begin bad++; $display("FAIL wr_oe got=%0d exp=0", oel); end
    endtask

    task automatic test_read;
        int lows, wlo, whi, oel; logic [31:0] rdv; logic rdy;
        xfer(1'b0, 1'b1, 32'd1028, 32'h0, lows, wlo, whi, oel, rdv, rdy);
        total++; if (rdv !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", rdv); end
        total++; if (lows !== 5) begin bad++; $display("FAIL rd_low_cycles got=%0d exp=5", lows); end
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL rd_done_ready got=%b exp=1", rdy); end
        total++; if (wlo + whi !== 0) begin bad++; $display("FAIL rd_we got=%0d exp=0", wlo + whi); end
        xfer(1'b1, 1'b0, 32'd1032, 32'h11112222, lows, wlo, whi, oel, rdv, rdy);
        total++; if (rdv !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_hold got=%h exp=deadbeef", rdv); end
        total++; if (mem[5] !== 16'h1111) begin bad++; $display("FAIL wr2_hi got=%h exp=1111", mem[5]); end
    endtask

    task automatic test_both;
        int lows, wlo, whi, oel; logic [31:0] rdv; logic rdy;
        xfer(1'b1, 1'b1, 32'd1024, 32'h12345678, lows, wlo, whi, oel, rdv, rdy);
        total++; if (oel !== 0) begin bad++; $display("FAIL both_oe got=%0d exp=0", oel); end
        total++; if (mem[0] !== 16'h5678) begin bad++; $display("FAIL both_w0 got=%h exp=5678", mem[0]); end
        total++; if (mem[1] !== 16'h1234) begin bad++; $display("FAIL both_w1 got=%h exp=1234", mem[1]); end
        total++; if (rdv !== 32'hDEADBEEF) begin bad++; $display("FAIL both_rdata got=%h exp=deadbeef", rdv); end
    endtask

    task automatic test_wait3;
        int lows;
        logic done;
        lows = 0; done = 1'b0;
        @(negedge clk);
        rd3 = 1'b1; address = 32'd1024;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (ready3) begin done = 1'b1; break; end
            lows++;
            @(negedge clk);
            #1;
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL w3_timeout got=%b exp=1", done); end
        total++; if (lows !== 9) begin bad++; $display("FAIL w3_low_cycles got=%0d exp=9", lows); end
        total++; if (read_data3 !== 32'hA001A000) begin
            bad++; $display("FAIL w3_rdata got=%h exp=a001a000", read_data3); end
        rd3 = 1'b0;
    endtask

    task automatic test_reset_mid;
        int lows, wlo, whi, oel; logic [31:0] rdv; logic rdy;
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        total++; if (sram_addr !== 18'd9) begin bad++; $display("FAIL rm_hi_addr got=%0d exp=9", sram_addr); end
        #2 rst = 1'b1;
        #1;
        total++; if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111) begin
            bad++; $display("FAIL rm_ctrl got=%b exp=11111", {ce_n, oe_n, we_n, ub_n, lb_n}); end
        total++; if (sram_dq_oe !== 1'b0 || sram_addr !== 18'h0 || sram_dq_out !== 16'h0) begin
            bad++; $display("FAIL rm_bus got=%b/%h/%h exp=0/0/0", sram_dq_oe, sram_addr, sram_dq_out); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL rm_ready_req got=%b exp=0", ready); end
        wr_en = 1'b0;
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL rm_ready_idle got=%b exp=1", ready); end
        @(negedge clk);
        rst = 1'b0;
        total++; if (mem[9] !== 16'h0) begin bad++; $display("FAIL rm_aborted got=%h exp=0", mem[9]); end
        total++; if (mem[8] !== 16'hF00D) begin bad++; $display("FAIL rm_lo_word got=%h exp=f00d", mem[8]); end
        xfer(1'b0, 1'b1, 32'd1028, 32'h0, lows, wlo, whi, oel, rdv, rdy);
        total++; if (lows !== 5) begin bad++; $display("FAIL rm_fresh_low got=%0d exp=5", lows); end
        total++; if (rdv !== 32'hDEADBEEF) begin bad++; $display("FAIL rm_fresh_rd got=%h exp=deadbeef", rdv); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        test_reset();
        test_write();
        test_read();
        test_both();
        test_wait3();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
